lfsr_crc32_fcs_insert: RTL and testbench
========================================

// Module: lfsr_crc32_fcs_insert
// PURPOSE
//  Streaming CRC-32 frame controller. Sequences one combinational lfsr instance configured for CRC-32:
//   LFSR_WIDTH=32, LFSR_POLY=32'h04c11db7, GALOIS, REVERSE=1, DATA_WIDTH=8, FEED_FORWARD=0.
//  Passes 8-bit AXI-stream frames through, optionally zero-pads short frames and appends the 4-byte FCS.
//  Sits between a byte-wide MAC TX datapath and the PHY-side serializer.
// PARAMETERS
//  ENABLE_PADDING    0   1: zero-pad payload to MIN_FRAME_LENGTH bytes before FCS.
//  MIN_FRAME_LENGTH  60  minimum payload length (bytes, excluding FCS) when padding is enabled; range 1..255.
// PORTS
//  clk            in   1  clock, all logic on rising edge
//  rst            in   1  asynchronous, active-high reset
//  s_axis_tdata   in   8  payload byte
//  s_axis_tvalid  in   1  payload byte valid
//  s_axis_tready  out  1  payload byte accepted when tvalid&tready
//  s_axis_tlast   in   1  last payload byte of frame
//  m_axis_tdata   out  8  output byte (payload, pad or FCS)
//  m_axis_tvalid  out  1  output byte valid
//  m_axis_tready  in   1  downstream ready
//  m_axis_tlast   out  1  asserted on final FCS byte only
//  busy           out  1  high from first accepted byte until last FCS byte transferred
// BEHAVIOUR
//  Reset (async assert) values:
//   - m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0
//   - s_axis_tready=0 while rst high
//   - crc state=32'hFFFFFFFF, state=PAYLOAD, byte count=0, FCS index=0
//  Output register: single stage. It loads when !m_axis_tvalid || m_axis_tready ("out_en").
//   - Output holds stable while m_axis_tvalid & !m_axis_tready.
//  Latency: accepted input byte appears on m_axis one cycle later; no bubbles under full throughput.
//  CRC: crc_next = lfsr(data_in=byte, state_in=crc). It is updated for every payload and pad byte loaded into the output register.
//   - FCS = ~crc, sent LSB byte first: FCS[7:0], [15:8], [23:16], [31:24].
//  FSM:
//   - PAYLOAD: s_axis_tready = out_en. Each accepted byte is forwarded with tlast=0; crc is updated and count is incremented (saturating at 255).
//     On accepted tlast: if ENABLE_PADDING and count+1 < MIN_FRAME_LENGTH -> PAD, else -> FCS.
//   - PAD: s_axis_tready=0. On each out_en, emit 8'h00 and update crc/count. When count reaches MIN_FRAME_LENGTH -> FCS.
//   - FCS: s_axis_tready=0. On each out_en, emit FCS byte idx 0..3. Idx 3 sets m_axis_tlast=1.
//     On idx 3 load: crc<=FFFFFFFF, count<=0, idx<=0, -> PAYLOAD.
//  FCS uses the crc value frozen at the end of payload/pad; it is not updated during FCS.
//  Back-to-back frames: the next frame's first byte is accepted in the cycle after the last FCS byte is loaded (tready reasserts per out_en).
//  Frame length 1 (tlast on first byte) is legal; frames always carry at least one payload byte.
//  Padding disabled, or payload >= MIN_FRAME_LENGTH: no pad bytes are inserted.
//  s_axis_tvalid low mid-frame: state holds and m_axis_tvalid drops after the pending byte is taken; crc and count are unaffected.
//  Reset mid-frame: partial frame is discarded with no tlast emitted. All state returns to reset values and the next accepted byte starts a new frame.
//  busy: set on first accepted byte of a frame; cleared when the tlast FCS byte completes (m_axis_tvalid&m_axis_tready&m_axis_tlast).
// TESTING
//  1. ASCII "123456789", tlast on '9', padding off, m_axis_tready=1
//     -> 9 payload bytes then 26 39 F4 CB; tlast on CB; 13 outputs in 13 consecutive cycles.
//  2. Single byte 8'h00 with tlast, padding off -> 00 8D EF 02 D2; tlast on D2 only.
//  3. ENABLE_PADDING=1, MIN_FRAME_LENGTH=60, 1-byte frame 8'hAA
//     -> AA, 59x 00, then 4 FCS bytes matching a software CRC-32 of the 60 bytes; 64 outputs total.
//  4. Case 1 with m_axis_tready toggled randomly (~50%) and s_axis_tvalid gaps
//     -> identical byte sequence; m_axis_tdata/tlast stable while stalled; no byte dropped or duplicated.
//  5. Two frames back-to-back ("123456789" then 8'h00)
//     -> second FCS = 8D EF 02 D2, proving crc re-init; zero idle cycles between frames.
//  6. rst pulsed after 4 payload bytes, then "123456789" sent
//     -> outputs and busy clear immediately; following frame yields 26 39 F4 CB.

Source files
------------

// File: rtl/lfsr_crc32_fcs_insert.sv
// rtl/lfsr_crc32_fcs_insert.sv - byte-stream CRC-32 frame controller: pass-through, optional zero pad, FCS append
// Holds a combinational Galois LFSR step helper and the frame controller that sequences it.

module lfsr #(
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c11db7,
  parameter bit                    REVERSE    = 1'b1,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV = reflect(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] st;
  logic                  fb;

  // Reflected mode shifts right and consumes data LSB first, matching Ethernet bit order.
  always_comb begin
    st = state_in;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = st[0] ^ data_in[i];
        st = st >> 1;
        if (fb) st = st ^ POLY_REV;
      end else begin
        fb = st[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        st = st << 1;
        if (fb) st = st ^ LFSR_POLY;
      end
    end
    state_out = st;
  end

endmodule

module lfsr_crc32_fcs_insert #(
  parameter bit ENABLE_PADDING   = 1'b0,
  parameter int MIN_FRAME_LENGTH = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       busy
);

  typedef enum logic [1:0] {ST_PAYLOAD, ST_PAD, ST_FCS} state_t;

  localparam logic [8:0] MIN_LEN = 9'(MIN_FRAME_LENGTH);

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        busy_q, busy_d;

  logic        out_en;
  logic        accept;
  logic [7:0]  crc_din;
  logic [31:0] crc_next;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;
  logic [7:0]  count_inc;

  assign out_en    = !tvalid_q || m_axis_tready;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign crc_din   = (state_q == ST_PAD) ? 8'h00 : s_axis_tdata;
  assign fcs       = ~crc_q;
  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    case (idx_q)
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  lfsr #(
    .LFSR_WIDTH(32),
    .LFSR_POLY (32'h04c11db7),
    .REVERSE   (1'b1),
    .DATA_WIDTH(8)
  ) u_crc_step (
    .data_in  (crc_din),
    .state_in (crc_q),
    .state_out(crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PAYLOAD;
      crc_q    <= 32'hFFFFFFFF;
      count_q  <= 8'd0;
      idx_q    <= 2'd0;
      tdata_q  <= 8'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    count_d  = count_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    // A new frame's first byte may be accepted in the same cycle the previous tlast leaves.
    if (tvalid_q && m_axis_tready && tlast_q) busy_d = 1'b0;
    if (out_en) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      case (state_q)
        ST_PAYLOAD: begin
          if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_tdata;
            crc_d    = crc_next;
            count_d  = count_inc;
            busy_d   = 1'b1;
            if (s_axis_tlast) begin
              if (ENABLE_PADDING && ({1'b0, count_q} + 9'd1 < MIN_LEN)) state_d = ST_PAD;
              else state_d = ST_FCS;
            end
          end
        end
        ST_PAD: begin
          tvalid_d = 1'b1;
          tdata_d  = 8'h00;
          crc_d    = crc_next;
          count_d  = count_inc;
          if ({1'b0, count_inc} >= MIN_LEN) state_d = ST_FCS;
        end
        ST_FCS: begin
          tvalid_d = 1'b1;
          tdata_d  = fcs_byte;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            tlast_d = 1'b1;
            crc_d   = 32'hFFFFFFFF;
            count_d = 8'd0;
            idx_d   = 2'd0;
            state_d = ST_PAYLOAD;
          end
        end
        default: state_d = ST_PAYLOAD;
      endcase
    end
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (!rst && state_q == ST_PAYLOAD) s_axis_tready = out_en;
    m_axis_tdata  = tdata_q;
    m_axis_tvalid = tvalid_q;
    m_axis_tlast  = tlast_q;
    busy          = busy_q;
  end

endmodule

// File: tb/tb_lfsr_crc32_fcs_insert.sv
// tb/tb_lfsr_crc32_fcs_insert.sv - bench for the CRC-32 FCS insert controller
// Two instances: padding off (sel=0) and padding to 60 bytes (sel=1).

module tb_lfsr_crc32_fcs_insert;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       m_tready = 1'b1;
  bit         sel = 1'b0;
  bit         rand_ready = 1'b0;

  logic       n_s_tvalid, n_s_tready, n_m_tvalid, n_m_tlast, n_busy;
  logic [7:0] n_m_tdata;
  logic       p_s_tvalid, p_s_tready, p_m_tvalid, p_m_tlast, p_busy;
  logic [7:0] p_m_tdata;

  assign n_s_tvalid = s_tvalid && !sel;
  assign p_s_tvalid = s_tvalid && sel;

  lfsr_crc32_fcs_insert #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(60)) dut_n (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(n_s_tvalid), .s_axis_tready(n_s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(n_m_tdata), .m_axis_tvalid(n_m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(n_m_tlast),
    .busy(n_busy)
  );

  lfsr_crc32_fcs_insert #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(60)) dut_p (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(p_m_tdata), .m_axis_tvalid(p_m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(p_m_tlast),
    .busy(p_busy)
  );

  logic       mon_tvalid, mon_tlast, mon_busy, mon_s_tready;
  logic [7:0] mon_tdata;
  assign mon_tvalid   = sel ? p_m_tvalid : n_m_tvalid;
  assign mon_tlast    = sel ? p_m_tlast  : n_m_tlast;
  assign mon_tdata    = sel ? p_m_tdata  : n_m_tdata;
  assign mon_busy     = sel ? p_busy     : n_busy;
  assign mon_s_tready = sel ? p_s_tready : n_s_tready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [8:0] sb[$];
  logic [7:0] frame[$];
  logic [8:0] got[$];
  int         gotcyc[$];
  bit         exp_busy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_out = 9'h0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Standard reflected CRC-32, computed MSB-first on bit-reversed input and result.
  function automatic logic [31:0] sw_crc32(input logic [7:0] msg[$]);
    logic [31:0] n;
    logic [31:0] r;
    logic        fb;
    n = 32'hFFFFFFFF;
    foreach (msg[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = n[31] ^ msg[k][j];
        n  = n << 1;
        if (fb) n = n ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) r[i] = n[31-i];
    return ~r;
  endfunction

  task automatic model_end_frame();
    logic [31:0] c;
    if (sel) begin
      while (frame.size() < 60) begin
        frame.push_back(8'h00);
        sb.push_back(9'h000);
      end
    end
    c = sw_crc32(frame);
    for (int k = 0; k < 4; k++) sb.push_back({k == 3, c[8*k +: 8]});
    frame.delete();
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (rst) begin
      sb.delete();
      frame.delete();
      exp_busy   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("busy", 32'(mon_busy), 32'(exp_busy));
      if (prev_stall) chk("stall_hold", {mon_tvalid, mon_tlast, mon_tdata}, {1'b1, prev_out});
      if (mon_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h, expected no output", {mon_tlast, mon_tdata});
        end else begin
          e = sb.pop_front();
          chk("out_byte", {mon_tlast, mon_tdata}, e);
        end
        got.push_back({mon_tlast, mon_tdata});
        gotcyc.push_back(cyc);
        if (mon_tlast) exp_busy = 1'b0;
      end
      if (s_tvalid && mon_s_tready) begin
        sb.push_back({1'b0, s_tdata});
        frame.push_back(s_tdata);
        exp_busy = 1'b1;
        if (s_tlast) model_end_frame();
      end
      prev_stall = mon_tvalid && !m_tready;
      prev_out   = {mon_tlast, mon_tdata};
    end
  end

  task automatic send(input logic [7:0] b[$], input bit with_last, input bit gaps, input bit hold);
    int i = 0;
    int guard = 0;
    while (i < b.size() && guard < 5000) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = b[i];
        s_tlast  = with_last && (i == b.size() - 1);
      end
      #1;
      if (s_tvalid && mon_s_tready) i++;
      guard++;
    end
    chk("send_timeout", 32'(i), 32'(b.size()));
    if (!hold) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !mon_tvalid) break;
    end
    chk({name, "_idle"}, 32'(k < 3000), 32'd1);
  endtask

  task automatic chk_fcs(input string name, input int s, input logic [31:0] exp);
    if (got.size() >= s + 4)
      chk(name, {got[s][7:0], got[s+1][7:0], got[s+2][7:0], got[s+3][7:0]}, exp);
    else
      chk({name, "_short"}, 32'(got.size()), 32'(s + 4));
  endtask

  function automatic logic [31:0] tlast_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < got.size() && i < 32; i++) m[i] = got[i][8];
    return m;
  endfunction

  function automatic int tlast_count();
    int c = 0;
    foreach (got[i]) c += int'(got[i][8]);
    return c;
  endfunction

  task automatic clear_log();
    got.delete();
    gotcyc.delete();
  endtask

  logic [7:0] q123[$];
  logic [7:0] q00[$];
  logic [7:0] qaa[$];
  logic [7:0] qn[$];

  initial begin
    for (int i = 0; i < 9; i++) q123.push_back(8'h31 + 8'(i));
    q00.push_back(8'h00);
    qaa.push_back(8'hAA);

    repeat (3) @(negedge clk);
    #2;
    chk("rst_n_tvalid", 32'(n_m_tvalid), 0);
    chk("rst_n_tdata",  32'(n_m_tdata),  0);
    chk("rst_n_tlast",  32'(n_m_tlast),  0);
    chk("rst_n_busy",   32'(n_busy),     0);
    chk("rst_n_tready", 32'(n_s_tready), 0);
    chk("rst_p_tvalid", 32'(p_m_tvalid), 0);
    chk("rst_p_busy",   32'(p_busy),     0);
    chk("rst_p_tready", 32'(p_s_tready), 0);
    @(negedge clk);
    rst = 1'b0;

    chk("model_crc_123456789", sw_crc32(q123), 32'hCBF43926);
    chk("model_crc_00", sw_crc32(q00), 32'hD202EF8D);

    // 1: check string, full throughput
    clear_log();
    send(q123, 1'b1, 1'b0, 1'b0);
    wait_idle("t1");
    chk("t1_count", 32'(got.size()), 13);
    chk_fcs("t1_fcs", 9, 32'h2639F4CB);
    chk("t1_tlast", tlast_mask(), 32'h1000);
    if (got.size() == 13) chk("t1_span", 32'(gotcyc[12] - gotcyc[0]), 12);

    // 2: single zero byte
    clear_log();
    send(q00, 1'b1, 1'b0, 1'b0);
    wait_idle("t2");
    chk("t2_count", 32'(got.size()), 5);
    if (got.size() > 0) chk("t2_first", 32'(got[0]), 32'h000);
    chk_fcs("t2_fcs", 1, 32'h8DEF02D2);
    chk("t2_tlast", tlast_mask(), 32'h10);

    // 4: random downstream stalls and input gaps
    rand_ready = 1'b1;
    clear_log();
    send(q123, 1'b1, 1'b1, 1'b0);
    wait_idle("t4");
    rand_ready = 1'b0;
    chk("t4_count", 32'(got.size()), 13);
    chk_fcs("t4_fcs", 9, 32'h2639F4CB);
    chk("t4_tlast", tlast_mask(), 32'h1000);

    // 5: back-to-back frames, no idle between
    clear_log();
    send(q123, 1'b1, 1'b0, 1'b1);
    send(q00, 1'b1, 1'b0, 1'b0);
    wait_idle("t5");
    chk("t5_count", 32'(got.size()), 18);
    chk_fcs("t5_fcs1", 9, 32'h2639F4CB);
    chk_fcs("t5_fcs2", 14, 32'h8DEF02D2);
    if (got.size() == 18) chk("t5_span", 32'(gotcyc[17] - gotcyc[0]), 17);

    // 3: padding instance
    sel = 1'b1;
    @(negedge clk);
    clear_log();
    send(qaa, 1'b1, 1'b0, 1'b0);
    wait_idle("t3");
    chk("t3_count", 32'(got.size()), 64);
    if (got.size() == 64) begin
      int z = 0;
      for (int i = 1; i < 60; i++) z += int'(got[i] == 9'h000);
      chk("t3_first", 32'(got[0]), 32'h0AA);
      chk("t3_zeros", 32'(z), 59);
      chk("t3_last", 32'(got[63][8]), 1);
    end
    chk("t3_tlast_count", 32'(tlast_count()), 1);
    for (int len = 59; len <= 61; len++) begin
      qn.delete();
      for (int i = 0; i < len; i++) qn.push_back(8'(i + 1));
      clear_log();
      send(qn, 1'b1, 1'b0, 1'b0);
      wait_idle("t3_len");
      chk("t3_len_count", 32'(got.size()), 32'((len < 60 ? 60 : len) + 4));
    end
    sel = 1'b0;
    @(negedge clk);

    // 6: reset mid-frame
    qn.delete();
    for (int i = 0; i < 4; i++) qn.push_back(8'hA0 + 8'(i));
    send(qn, 1'b0, 1'b0, 1'b0);
    #2;
    chk("t6_busy_before", 32'(n_busy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 32'(n_m_tvalid), 0);
    chk("t6_rst_busy",   32'(n_busy),     0);
    chk("t6_rst_tlast",  32'(n_m_tlast),  0);
    chk("t6_rst_tready", 32'(n_s_tready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
    send(q123, 1'b1, 1'b0, 1'b0);
    wait_idle("t6");
    chk("t6_count", 32'(got.size()), 13);
    chk_fcs("t6_fcs", 9, 32'h2639F4CB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
